// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_pkg
// Description : Shared types for the w_serializer front end.
//               ser_state_t - serializer FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_t;

endpackage : serial_pkg
`default_nettype wire

// File: rtl/bit_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : bit_tick_gen
// Description : Bit-period divider. A down-counter that is reloaded to
//               CLKS_PER_BIT-1 on load_i and otherwise counts down to zero
//               while en_i is high. tick_o flags the final clock of a bit.
// Ports       : clk     - clock, rising edge
//               rst_n   - asynchronous active-low reset (counter -> 0)
//               load_i  - reload the counter (wins over en_i)
//               en_i    - allow the counter to decrement
//               tick_o  - counter is zero
// Revision    : 1.0 - initial release
// ============================================================================
module bit_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned c_CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [c_CNT_W-1:0] c_RELOAD = c_CNT_W'(CLKS_PER_BIT - 1);

  logic [c_CNT_W-1:0] cnt_q;
  logic [c_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = c_RELOAD;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule : bit_tick_gen
`default_nettype wire

// File: rtl/w_serializer.sv
`default_nettype none
// ============================================================================
// Module      : w_serializer
// Description : Parallel-to-serial front end producing the registered w
//               stream for the downstream sequence detector. Words are
//               accepted on a valid/ready handshake and shifted out one bit
//               at a time, each bit held CLKS_PER_BIT clocks. Back-to-back
//               words run with no gap; otherwise w rests at IDLE_LEVEL.
// Ports       : clk        - clock, rising edge
//               Reset      - asynchronous active-low reset
//               din        - word to serialize (sampled on accept only)
//               din_valid  - din holds a word
//               din_ready  - a word can be accepted this cycle
//               w          - serial bit stream (registered)
//               w_valid    - high on the first clock of each bit
//               busy       - a word is in flight
// Revision    : 1.0 - initial release
// ============================================================================
module w_serializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter bit          MSB_FIRST    = 1'b1,
  parameter bit          IDLE_LEVEL   = 1'b0
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             w,
  output logic             w_valid,
  output logic             busy
);

  localparam int unsigned c_BIT_W = $clog2(WIDTH + 1);
  localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(WIDTH - 1);

  ser_state_t         state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [c_BIT_W-1:0] bitcnt_q, bitcnt_d;
  logic               w_q, w_d;
  logic               w_valid_q, w_valid_d;

  logic               tick;
  logic               div_load;
  logic               last_cycle;
  logic               accept;
  logic [WIDTH-1:0]   shreg_nxt;
  logic               din_first_bit;
  logic               next_bit;

  // Bit order is fixed at elaboration: the outgoing bit always sits at the
  // "front" end of the shift register, so the next bit is read from the
  // register after it has been shifted. For WIDTH=1 the shifted value is
  // never used because every divider expiry is a last cycle.
  if (MSB_FIRST) begin : g_msb_first
    assign shreg_nxt     = shreg_q << 1;
    assign din_first_bit = din[WIDTH-1];
    assign next_bit      = shreg_nxt[WIDTH-1];
  end else begin : g_lsb_first
    assign shreg_nxt     = shreg_q >> 1;
    assign din_first_bit = din[0];
    assign next_bit      = shreg_nxt[0];
  end

  bit_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tick (
    .clk    (clk),
    .rst_n  (Reset),
    .load_i (div_load),
    .en_i   (state_q == S_SHIFT),
    .tick_o (tick)
  );

  // Ready is a pure decode of registered state so there is no
  // combinational path from din_valid back to din_ready.
  assign last_cycle = (state_q == S_SHIFT) && tick && (bitcnt_q == '0);
  assign din_ready  = (state_q == S_IDLE) || last_cycle;
  assign accept     = din_valid && din_ready;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    w_d       = w_q;
    w_valid_d = 1'b0;
    div_load  = 1'b0;

    if (accept) begin
      // Same load path from IDLE and from the last cycle of a word,
      // which is what makes back-to-back words gapless.
      state_d   = S_SHIFT;
      shreg_d   = din;
      bitcnt_d  = c_LAST_BIT;
      w_d       = din_first_bit;
      w_valid_d = 1'b1;
      div_load  = 1'b1;
    end else if (state_q == S_SHIFT) begin
      if (tick) begin
        if (bitcnt_q != '0) begin
          shreg_d   = shreg_nxt;
          bitcnt_d  = bitcnt_q - 1'b1;
          w_d       = next_bit;
          w_valid_d = 1'b1;
          div_load  = 1'b1;
        end else begin
          state_d = S_IDLE;
          w_d     = IDLE_LEVEL;
        end
      end
    end else begin
      w_d = IDLE_LEVEL;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      w_q       <= IDLE_LEVEL;
      w_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      w_q       <= w_d;
      w_valid_q <= w_valid_d;
    end
  end

  assign w       = w_q;
  assign w_valid = w_valid_q;
  assign busy    = (state_q == S_SHIFT);

endmodule : w_serializer
`default_nettype wire
